// File: rtl/multiply_result_to_sign_bcd_pkg.sv
// Shared calculator definitions: FSM encoding and fixed datapath sizes.
package multiply_result_to_sign_bcd_pkg;

  localparam int DATA_W       = 8;
  localparam int BCD_DIGITS   = 3;
  localparam int SERIAL_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NEGATE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/multiply_result_to_sign_bcd_bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module multiply_result_to_sign_bcd_bcd_add3
  import multiply_result_to_sign_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/multiply_result_to_sign_bcd.sv
// Converts an 8-bit two's-complement product to sign + three BCD digits using a
// bit-serial negation pass (negative inputs only) followed by an 8-step
// iterative double-dabble.
module multiply_result_to_sign_bcd
  import multiply_result_to_sign_bcd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] result_in,
  output logic                     busy,
  output logic                     done,
  output logic                     sign,
  output logic [3:0]               bcd_hundreds,
  output logic [3:0]               bcd_tens,
  output logic [3:0]               bcd_units
);

  localparam logic [2:0] LAST_STEP = 3'(SERIAL_STEPS - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [DATA_W-1:0]        r_mag;
  logic                     r_sign_lat;
  logic                     r_seen_one;
  logic [2:0]               r_cnt;
  logic [4*BCD_DIGITS-1:0]  r_bcd;

  logic                     w_idle_like;
  logic                     w_last;
  logic                     w_bit;
  logic                     w_neg_bit;
  logic [4*BCD_DIGITS-1:0]  w_corr;
  logic [4*BCD_DIGITS-1:0]  w_shift_bcd;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  assign w_last      = (r_cnt == LAST_STEP);
  assign busy        = (r_state == NEGATE) || (r_state == CONVERT);

  // Serial negation: copy bits up to and including the first 1, invert the rest.
  assign w_bit     = r_mag[r_cnt];
  assign w_neg_bit = r_seen_one ? ~w_bit : w_bit;

  multiply_result_to_sign_bcd_bcd_add3 u_add3_h (.i_digit(r_bcd[11:8]), .o_digit(w_corr[11:8]));
  multiply_result_to_sign_bcd_bcd_add3 u_add3_t (.i_digit(r_bcd[7:4]),  .o_digit(w_corr[7:4]));
  multiply_result_to_sign_bcd_bcd_add3 u_add3_u (.i_digit(r_bcd[3:0]),  .o_digit(w_corr[3:0]));

  // Corrected digits shifted left by one, pulling in the magnitude MSB.
  assign w_shift_bcd = {w_corr[4*BCD_DIGITS-2:0], r_mag[DATA_W-1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; start is honoured only when no conversion is in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = result_in[DATA_W-1] ? NEGATE : CONVERT;
      NEGATE:     if (w_last) w_next = CONVERT;
      CONVERT:    if (w_last) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  // Datapath: capture, serial negation, double-dabble and output loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag        <= '0;
      r_sign_lat   <= 1'b0;
      r_seen_one   <= 1'b0;
      r_cnt        <= '0;
      r_bcd        <= '0;
      done         <= 1'b0;
      sign         <= 1'b0;
      bcd_hundreds <= '0;
      bcd_tens     <= '0;
      bcd_units    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mag      <= $unsigned(result_in);
            r_sign_lat <= result_in[DATA_W-1];
            r_seen_one <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            done       <= 1'b0;
          end
        end
        NEGATE: begin
          r_mag[r_cnt] <= w_neg_bit;
          r_seen_one   <= r_seen_one | w_bit;
          r_cnt        <= w_last ? 3'd0 : r_cnt + 3'd1;
        end
        CONVERT: begin
          r_bcd <= w_shift_bcd;
          r_mag <= {r_mag[DATA_W-2:0], 1'b0};
          r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
          if (w_last) begin
            sign         <= r_sign_lat;
            bcd_hundreds <= w_shift_bcd[11:8];
            bcd_tens     <= w_shift_bcd[7:4];
            bcd_units    <= w_shift_bcd[3:0];
            done         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_result_to_sign_bcd.sv
// Self-checking bench: directed boundaries, randomized products, busy-start
// rejection, asynchronous reset mid-conversion and back-to-back starts.
module tb_multiply_result_to_sign_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] result_in;
  logic       busy, done, sign;
  logic [3:0] bcd_hundreds, bcd_tens, bcd_units;

  int n_vec = 0;
  int n_err = 0;

  // Values the display should currently be showing.
  logic       e_sign;
  logic [3:0] e_h, e_t, e_u;

  multiply_result_to_sign_bcd dut (
    .clk(clk), .rst(rst), .start(start), .result_in(result_in),
    .busy(busy), .done(done), .sign(sign),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_units(bcd_units)
  );

  always #5 clk = ~clk;

  // Reference: magnitude by plain arithmetic, digits by division.
  function automatic void ref_model(input logic [7:0] v, output logic s,
                                    output logic [3:0] h, output logic [3:0] t,
                                    output logic [3:0] u);
    int m;
    s = v[7];
    m = v[7] ? 256 - int'(v) : int'(v);
    h = 4'(m / 100);
    t = 4'((m / 10) % 10);
    u = 4'(m % 10);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; result_in = 8'h19;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_units} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b sign=%b digits=%h%h%h, want all 0",
               busy, done, sign, bcd_hundreds, bcd_tens, bcd_units);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    e_sign = 1'b0; e_h = 4'd0; e_t = 4'd0; e_u = 4'd0;
  endtask

  // One full conversion; optionally leaves start high afterwards.
  task automatic test_conversion(input logic [7:0] v, input bit keep_start);
    logic       s;
    logic [3:0] h, t, u;
    int         lat;
    ref_model(v, s, h, t, u);
    lat = v[7] ? 16 : 8;
    @(negedge clk); start = 1'b1; result_in = v;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    n_vec++;
    if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_units} !== {2'b10, e_sign, e_h, e_t, e_u}) begin
      n_err++;
      $display("FAIL capture_%h: got busy=%b done=%b out=%b/%h%h%h, want busy=1 done=0 out=%b/%h%h%h",
               v, busy, done, sign, bcd_hundreds, bcd_tens, bcd_units, e_sign, e_h, e_t, e_u);
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (k < lat) begin
        if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_units} !== {2'b10, e_sign, e_h, e_t, e_u}) begin
          n_err++;
          $display("FAIL busy_%h_E%0d: got busy=%b done=%b out=%b/%h%h%h, want busy=1 done=0 out=%b/%h%h%h",
                   v, k, busy, done, sign, bcd_hundreds, bcd_tens, bcd_units, e_sign, e_h, e_t, e_u);
        end
      end else begin
        if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_units} !== {2'b01, s, h, t, u}) begin
          n_err++;
          $display("FAIL result_%h_E%0d: got busy=%b done=%b out=%b/%h%h%h, want busy=0 done=1 out=%b/%h%h%h",
                   v, k, busy, done, sign, bcd_hundreds, bcd_tens, bcd_units, s, h, t, u);
        end
      end
    end
    e_sign = s; e_h = h; e_t = t; e_u = u;
  endtask

  task automatic test_directed();
    logic [7:0] vecs [6] = '{8'h19, 8'hC8, 8'h80, 8'h00, 8'hFF, 8'h40};
    foreach (vecs[i]) test_conversion(vecs[i], 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] v;
    int         gap;
    for (int i = 0; i < 24; i++) begin
      v   = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      #1;
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL done_hold_%0d: got done=%b busy=%b, want done=1 busy=0", i, done, busy);
      end
      test_conversion(v, 1'b0);
    end
  endtask

  task automatic test_busy_ignore();
    @(negedge clk); start = 1'b1; result_in = 8'h07;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin start = 1'b1; result_in = 8'hF9; end
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 8) begin
        n_vec++;
        if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_units} !== {2'b01, 1'b0, 12'h007}) begin
          n_err++;
          $display("FAIL busy_ignore: got busy=%b done=%b out=%b/%h%h%h, want busy=0 done=1 out=0/007",
                   busy, done, sign, bcd_hundreds, bcd_tens, bcd_units);
        end
      end
    end
    e_sign = 1'b0; e_h = 4'd0; e_t = 4'd0; e_u = 4'd7;
  endtask

  task automatic test_rst_mid();
    @(negedge clk); start = 1'b1; result_in = 8'hC8;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_units} !== 15'd0) begin
      n_err++;
      $display("FAIL rst_async: got busy=%b done=%b out=%b/%h%h%h, want all 0",
               busy, done, sign, bcd_hundreds, bcd_tens, bcd_units);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    e_sign = 1'b0; e_h = 4'd0; e_t = 4'd0; e_u = 4'd0;
    test_conversion(8'h0C, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_conversion(8'h9C, 1'b1);
    test_conversion(8'h2D, 1'b1);
    test_conversion(8'h63, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiply_result_to_sign_bcd.md
# multiply_result_to_sign_bcd

Back-end converter for the calculator multiply path: takes the 8-bit two's-complement product and converts it to sign-magnitude, then to three BCD digits for the display driver. It mirrors the front-end complement stage, which converts the operands into two's complement. Both conversions run serially with a start/done handshake: a bit-serial negation when the product is negative, then an iterative double-dabble.

## Interface
Parameters:
- None. Data width is fixed at 8 bits, the signed product of two 4-bit operands.

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request conversion of result_in; sampled only in IDLE or DONE
- result_in  in  8  two's-complement product, captured on the accepted start edge
- busy  out  1  high in NEGATE and CONVERT
- done  out  1  result valid; level, held until the next accepted start
- sign  out  1  1 = negative result
- bcd_hundreds  out  4  hundreds digit (0–1)
- bcd_tens  out  4  tens digit (0–9)
- bcd_units  out  4  units digit (0–9)

## Operation
- Reset values: all outputs 0; state IDLE; internal registers 0.
- States: IDLE, NEGATE, CONVERT, DONE.
- IDLE or DONE with start=1, on the capture edge:
  - latch result_in into mag[7:0] and result_in[7] into a sign register;
  - clear done; clear bit counter cnt[2:0];
  - next state is NEGATE if result_in[7]=1, otherwise CONVERT.
- NEGATE, 8 cycles, bit i = cnt, LSB first:
  - new_bit = seen_one ? ~mag[i] : mag[i]; then seen_one |= mag[i];
  - cnt increments; at cnt=7 go to CONVERT with cnt cleared.
  - Net effect: two's-complement negation. The 8-bit magnitude is unsigned, so 8'h80 yields 128.
- CONVERT, 8 cycles, double-dabble over a 20-bit shift register {H,T,U,mag}:
  - add-3 correction on each BCD digit that is ≥5, then shift left by 1;
  - at cnt=7, load sign and the digit outputs from the corrected-and-shifted value, set done=1, go to DONE.
- DONE: outputs and done are held. A new start restarts conversion from the capture edge.
- start while busy: ignored, with no effect on the in-flight conversion.
- start and rst together: rst wins.
- Outputs change only at the final CONVERT edge and on reset. done clears at the capture edge; the digit outputs keep their old values until the new result loads.

## Timing
- Capture edge = E0.
- Non-negative input:
  - CONVERT shifts on E1–E8;
  - done=1 and outputs valid after E8;
  - busy high from after E0 through E8.
- Negative input:
  - NEGATE on E1–E8, CONVERT on E9–E16;
  - done=1 and outputs valid after E16.
- done and busy are never high together.
- Back-to-back: start held high in DONE is accepted on the next edge, so there is 1 idle cycle minimum between results.
- rst asserted mid-operation: all outputs go to 0 immediately (asynchronous), state goes to IDLE, and the partial result is discarded.

## Structure
- Shared calculator package holds:
  - state encoding: IDLE=2'd0, NEGATE=2'd1, CONVERT=2'd2, DONE=2'd3;
  - constants: DATA_W=8, BCD_DIGITS=3, SERIAL_STEPS=8.
- Sub-module bcd_add3: 4-bit combinational "if ≥5 add 3" cell, instantiated three times, once per digit.
- The top level holds the FSM, bit counter, negation datapath and shift register.

## Test plan
- result_in=8'h19 with start pulse → done after E8; sign=0, digits 0/2/5; busy high for exactly 8 cycles.
- result_in=8'hC8 (−56) → done after E16; sign=1, digits 0/5/6.
- Boundaries:
  - 8'h80 → sign=1, digits 1/2/8;
  - 8'h00 → sign=0, digits 0/0/0;
  - 8'hFF → sign=1, digits 0/0/1;
  - 8'h40 (64) → sign=0, digits 0/6/4.
- Start 8'h07, then start with 8'hF9 at E3 while busy → the second start is ignored; result sign=0, digits 0/0/7 after E8.
- rst asserted at E5 of a negative conversion → all outputs 0 immediately, FSM in IDLE; a following start of 8'h0C gives 0/1/2 with correct latency.
- Start held high in DONE → new capture on the next edge, done drops at that edge, and the new result appears with the correct latency.
